// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator; sub-word stores are read-modify-write.
// Optional: define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_access_unit #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       base,
    input  logic [15:0]       offset,
    input  logic [DATA_W-1:0] store_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_exc,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        op_q;
    logic [ADDR_W+1:0] ea_q;
    logic [31:0]       wdata_q;
    logic [31:0]       res_q;
    logic              exc_q;

    logic [31:0] ea;
    logic        unused_ea;
    logic        in_legal;
    logic        in_sw;
    logic        in_misal;

    assign ea = base + {{16{offset[15]}}, offset};
    // Upper EA bits wrap within memory.
    assign unused_ea = ^ea[31:ADDR_W+2];

    always_comb begin
        in_legal = 1'b1;
        in_sw    = 1'b0;
        unique case (req_op)
            OP_LB, OP_LH, OP_LW,
            OP_LBU, OP_LHU,
            OP_SB, OP_SH: ;
            OP_SW:        in_sw = 1'b1;
            default:      in_legal = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic in_half;
    logic in_word;
    assign in_half = (req_op == OP_LH) ||
                     (req_op == OP_LHU) ||
                     (req_op == OP_SH);
    assign in_word = (req_op == OP_LW) ||
                     (req_op == OP_SW);
    assign in_misal = (in_half && ea[0]) ||
                      (in_word && (ea[1:0] != 2'b00));
`else
    assign in_misal = 1'b0;
`endif

    logic [1:0]  lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] loaded;
    logic [31:0] merged;

    assign lane = ea_q[1:0];

    always_comb begin
        rd_byte = mem_rdata[{lane, 3'b000} +: 8];
        rd_half = ea_q[1] ? mem_rdata[31:16]
                          : mem_rdata[15:0];
        unique case (op_q)
            OP_LB:   loaded = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  loaded = {24'h0, rd_byte};
            OP_LH:   loaded = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  loaded = {16'h0, rd_half};
            default: loaded = mem_rdata;
        endcase
    end

    // Only the addressed byte/half is replaced; other lanes keep memory contents.
    always_comb begin
        merged = mem_rdata;
        if (op_q == OP_SB)
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{ea_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (!in_legal || in_misal)
                        state_d = S_DONE;
                    else if (in_sw)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:   state_d = op_q[3] ? S_WR : S_DONE;
            S_WR:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
            ea_q    <= '0;
            wdata_q <= 32'h0;
            res_q   <= 32'h0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        ea_q    <= ea[ADDR_W+1:0];
                        wdata_q <= store_data;
                        res_q   <= 32'h0;
                        exc_q   <= !in_legal || in_misal;
                    end
                end
                S_RD: begin
                    if (op_q[3])
                        wdata_q <= merged;
                    else
                        res_q <= loaded;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_read   = (state_q == S_RD);
    assign mem_write  = (state_q == S_WR);
    assign resp_valid = (state_q == S_DONE);

    assign mem_addr  = (mem_read || mem_write) ?
                       ea_q[ADDR_W+1:2] : '0;
    assign mem_wdata = mem_write ? wdata_q : '0;
    assign resp_data = resp_valid ? res_q : '0;
    assign resp_exc  = resp_valid && exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a word memory model.
// Expected values follow MISALIGN_TRAP_EN when it is defined.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] base = 32'h0;
    logic [15:0] offset = 16'h0;
    logic [31:0] store_data = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_exc;
    logic        mem_read;
    logic        mem_write;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:8191];

    always #5 clock = ~clock;

    assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

    mem_access_unit dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_exc   (resp_exc),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t got;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;
    logic [12:0] rd_addr = '0;
    logic [12:0] wr_addr = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h",
                     name, act, exp);
        end
    endtask

    // Monitor: memory model, strobe tracking and response scoreboard.
    always @(negedge clock) begin
        if (mem_read || mem_write)
            check("strobe_excl",
                  {31'h0, mem_read & mem_write}, 32'h0);
        if (mem_read) begin
            n_rd++;
            rd_addr = mem_addr;
            rd_cyc = cyc;
        end
        if (mem_write) begin
            n_wr++;
            wr_addr = mem_addr;
            wr_cyc = cyc;
            mem[mem_addr] = mem_wdata;
        end
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'h1, 32'h0);
            end else begin
                got = sb_q.pop_front();
                check("resp_data", resp_data, got.data);
                check("resp_exc", {31'h0, resp_exc},
                      {31'h0, got.exc});
                check("resp_cycle", cyc, got.cyc);
            end
        end
    end

    task automatic start(input logic [3:0] op,
                         input logic [31:0] b,
                         input logic [15:0] off,
                         input logic [31:0] sd,
                         output int acc);
        n_rd = 0;
        n_wr = 0;
        req_op = op;
        base = b;
        offset = off;
        store_data = sd;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (sb_q.size() != 0) begin
            check("resp_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input logic [3:0] op,
                          input logic [31:0] b,
                          input logic [15:0] off,
                          input logic [31:0] sd,
                          input logic [31:0] ed,
                          input logic ee,
                          input int lat);
        int acc;
        exp_t x;
        start(op, b, off, sd, acc);
        x.data = ed;
        x.exc = ee;
        x.cyc = acc + lat - 1;
        sb_q.push_back(x);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        logic [31:0] w5;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[5] = 32'h8899AABB;
        mem[8191] = 32'h01234567;

        // A request held during reset must be ignored.
        req_op = 4'b0010;
        base = 32'h10;
        offset = 16'd4;
        req_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("rst_flags",
              {27'h0, req_ready, resp_valid, resp_exc,
               mem_read, mem_write}, 32'h10);
        check("rst_addr", {19'h0, mem_addr}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", resp_data, 32'h0);
        check("rst_no_read", n_rd, 0);
        @(posedge clock);
        #1;

        do_req(4'b0010, 32'h10, 16'd4, 32'h0,
               32'h8899AABB, 1'b0, 2);
        check("lw_nrd", n_rd, 1);
        check("lw_addr", {19'h0, rd_addr}, 32'd5);
        check("lw_nwr", n_wr, 0);

        do_req(4'b0000, 32'h14, 16'd1, 32'h0,
               32'hFFFFFFAA, 1'b0, 2);
        do_req(4'b0100, 32'h14, 16'd1, 32'h0,
               32'h000000AA, 1'b0, 2);
        do_req(4'b0101, 32'h18, 16'hFFFE, 32'h0,
               32'h00008899, 1'b0, 2);
        do_req(4'b0001, 32'h18, 16'hFFFE, 32'h0,
               32'hFFFF8899, 1'b0, 2);
        do_req(4'b0000, 32'h14, 16'd3, 32'h0,
               32'hFFFFFF88, 1'b0, 2);
        do_req(4'b0100, 32'h14, 16'd0, 32'h0,
               32'h000000BB, 1'b0, 2);

        do_req(4'b1000, 32'h14, 16'd3, 32'h12,
               32'h0, 1'b0, 3);
        check("sb_word", mem[5], 32'h1299AABB);
        check("sb_nrd", n_rd, 1);
        check("sb_nwr", n_wr, 1);
        check("sb_order", wr_cyc, rd_cyc + 1);

        do_req(4'b1001, 32'h14, 16'd2, 32'h0000BEEF,
               32'h0, 1'b0, 3);
        check("sh_word", mem[5], 32'hBEEFAABB);

        do_req(4'b1010, 32'h0, 16'd0, 32'hDEADBEEF,
               32'h0, 1'b0, 2);
        check("sw_word", mem[0], 32'hDEADBEEF);
        check("sw_nrd", n_rd, 0);
        check("sw_nwr", n_wr, 1);
        check("sw_addr", {19'h0, wr_addr}, 32'h0);

        do_req(4'b0010, 32'h8000, 16'd0, 32'h0,
               32'hDEADBEEF, 1'b0, 2);
        do_req(4'b0010, 32'h0, 16'hFFFC, 32'h0,
               32'h01234567, 1'b0, 2);
        check("wrap_addr", {19'h0, rd_addr}, 32'd8191);

`ifdef MISALIGN_TRAP_EN
        do_req(4'b0010, 32'h15, 16'd0, 32'h0,
               32'h0, 1'b1, 1);
        check("mis_lw_nrd", n_rd, 0);
        do_req(4'b0001, 32'h15, 16'd0, 32'h0,
               32'h0, 1'b1, 1);
        do_req(4'b1001, 32'h17, 16'd0, 32'h1111,
               32'h0, 1'b1, 1);
        check("mis_sh_nwr", n_wr, 0);
        check("mis_sh_word", mem[5], 32'hBEEFAABB);
`else
        do_req(4'b0010, 32'h15, 16'd0, 32'h0,
               32'hBEEFAABB, 1'b0, 2);
        check("mis_lw_nrd", n_rd, 1);
        do_req(4'b0001, 32'h15, 16'd0, 32'h0,
               32'hFFFFAABB, 1'b0, 2);
        do_req(4'b1001, 32'h17, 16'd0, 32'h1111,
               32'h0, 1'b0, 3);
        check("mis_sh_nwr", n_wr, 1);
        check("mis_sh_word", mem[5], 32'h1111AABB);
`endif
        w5 = mem[5];

        do_req(4'b0011, 32'h14, 16'd0, 32'h55,
               32'h0, 1'b1, 1);
        check("ill_strobes", n_rd + n_wr, 0);
        do_req(4'b1111, 32'h0, 16'd0, 32'hFFFFFFFF,
               32'h0, 1'b1, 1);
        check("ill2_strobes", n_rd + n_wr, 0);
        check("ill2_mem0", mem[0], 32'hDEADBEEF);

        // Reset while in RD: request dropped silently.
        start(4'b0010, 32'h0, 16'd0, 32'h0, acc);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_rd_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rd_nrd", n_rd, 1);
        repeat (4) @(negedge clock);
        @(posedge clock);
        #1;

        do_req(4'b0010, 32'h10, 16'd4, 32'h0,
               w5, 1'b0, 2);

        // Reset while in WR: the write still lands.
        start(4'b1010, 32'h0, 16'd8, 32'hCAFEF00D, acc);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_wr_ready", {31'h0, req_ready}, 32'h1);
        check("rst_wr_word", mem[2], 32'hCAFEF00D);
        repeat (4) @(negedge clock);

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
